// File: rtl/des_search_pkg.sv
// Shared types and helpers for the DES key-search engine.
//   KEY_W / BLK_W : raw key-index width and DES block width
//   state_e       : search controller states
//   expand_key    : 56-bit candidate index -> 64-bit DES key with odd-parity bits
package des_search_pkg;

  localparam int unsigned KEY_W = 56;
  localparam int unsigned BLK_W = 64;

  typedef enum logic [1:0] {
    StIdle,
    StSearch,
    StFound,
    StExhausted
  } state_e;

  // Each 7-bit slice of the index becomes the top of one key byte; the byte LSB
  // is chosen so the byte carries an odd number of ones.
  function automatic logic [BLK_W-1:0] expand_key(input logic [KEY_W-1:0] idx);
    logic [6:0]       seg;
    logic [BLK_W-1:0] key;
    key = '0;
    for (int i = 0; i < 8; i++) begin
      seg            = idx[7*i +: 7];
      key[8*i +: 8]  = {seg, ~^seg};
    end
    return key;
  endfunction

endpackage

// File: rtl/des_encrypt.sv
// Purely combinational single-block DES encryption (16 rounds unrolled).
//   key_i        : 64-bit DES key (parity bits ignored)
//   plaintext_i  : 64-bit input block
//   ciphertext_o : 64-bit encrypted block
// Tables use the standard 1-based numbering where bit 1 is the vector MSB.
module des_encrypt (
  input  logic [63:0] key_i,
  input  logic [63:0] plaintext_i,
  output logic [63:0] ciphertext_o
);

  localparam int unsigned IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int unsigned FP_TAB [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int unsigned E_TAB [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int unsigned P_TAB [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
     2, 8, 24, 14, 32, 27,  3,  9, 19, 13, 30, 6, 22, 11, 4, 25};

  localparam int unsigned PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam int unsigned SHIFT_TAB [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Each box flattened row-major: entry index = {row[1:0], col[3:0]}.
  localparam int unsigned S_TAB [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
      0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
      3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
      1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
      3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
      4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
      6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
      1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
      2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

  // Round function: expand, mix in subkey, substitute, permute.
  function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s;
    logic [31:0] f;
    logic [5:0]  b;
    logic [5:0]  idx;
    e   = '0;
    s   = '0;
    f   = '0;
    b   = '0;
    idx = '0;
    for (int i = 0; i < 48; i++) e[47-i] = r[32-E_TAB[i]];
    e = e ^ k;
    for (int j = 0; j < 8; j++) begin
      b   = e[47-6*j -: 6];
      // Outer bits select the row, inner four bits the column.
      idx = {b[5], b[0], b[4:1]};
      s[31-4*j -: 4] = S_TAB[j][idx][3:0];
    end
    for (int i = 0; i < 32; i++) f[31-i] = s[32-P_TAB[i]];
    return f;
  endfunction

  logic [55:0] cd;
  logic [27:0] c;
  logic [27:0] d;
  logic [47:0] subkey;
  logic [63:0] ip;
  logic [63:0] pre;
  logic [31:0] l;
  logic [31:0] r;
  logic [31:0] t;

  always_comb begin
    cd           = '0;
    c            = '0;
    d            = '0;
    subkey       = '0;
    ip           = '0;
    pre          = '0;
    l            = '0;
    r            = '0;
    t            = '0;
    ciphertext_o = '0;

    for (int i = 0; i < 56; i++) cd[55-i] = key_i[64-PC1_TAB[i]];
    c = cd[55:28];
    d = cd[27:0];

    for (int i = 0; i < 64; i++) ip[63-i] = plaintext_i[64-IP_TAB[i]];
    l = ip[63:32];
    r = ip[31:0];

    for (int rnd = 0; rnd < 16; rnd++) begin
      if (SHIFT_TAB[rnd] == 1) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end else begin
        c = {c[25:0], c[27:26]};
        d = {d[25:0], d[27:26]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) subkey[47-i] = cd[56-PC2_TAB[i]];
      t = r;
      r = l ^ f_func(r, subkey);
      l = t;
    end

    // Halves are swapped before the final permutation.
    pre = {r, l};
    for (int i = 0; i < 64; i++) ciphertext_o[63-i] = pre[64-FP_TAB[i]];
  end

endmodule

// File: rtl/des_search_top.sv
// Brute-force DES key search: steps a 56-bit candidate index, expands it to a
// parity-correct key, encrypts the known plaintext and stops on a match.
//   clk        : rising-edge clock
//   reset      : synchronous active-high reset
//   Start      : one-cycle pulse launching (or relaunching) a search
//   plaintext  : known plaintext block
//   ciphertext : target ciphertext block
//   count      : current candidate index
//   Key        : candidate DES key derived from count
//   Found      : registered match flag
module des_search_top
  import des_search_pkg::*;
#(
  parameter logic [KEY_W-1:0] COUNT_LIMIT = 56'hFF_FFFF_FFFF_FFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [BLK_W-1:0] plaintext,
  input  logic [BLK_W-1:0] ciphertext,
  output logic [KEY_W-1:0] count,
  output logic [BLK_W-1:0] Key,
  output logic             Found
);

  state_e           state_q;
  logic [KEY_W-1:0] count_q;
  logic             found_q;
  logic [BLK_W-1:0] trial_ct;
  logic             match;

  assign Key = expand_key(count_q);

  des_encrypt u_des (
    .key_i       (Key),
    .plaintext_i (plaintext),
    .ciphertext_o(trial_ct)
  );

  assign match = (trial_ct == ciphertext);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
      found_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          count_q <= '0;
          found_q <= 1'b0;
          if (Start) state_q <= StSearch;
        end
        StSearch: begin
          // A match on the last candidate still counts as found.
          if (match) begin
            state_q <= StFound;
            found_q <= 1'b1;
          end else if (count_q == COUNT_LIMIT) begin
            state_q <= StExhausted;
          end else begin
            count_q <= count_q + 56'd1;
          end
        end
        StFound, StExhausted: begin
          if (Start) begin
            state_q <= StSearch;
            count_q <= '0;
            found_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          count_q <= '0;
          found_q <= 1'b0;
        end
      endcase
    end
  end

  assign count = count_q;
  assign Found = found_q;

endmodule

// File: tb/tb_des_search_top.sv
// Self-checking bench for des_search_top: known-answer search, randomized
// searches against a software DES key-search model, exhaustion with a small
// limit, reset priority and key parity.
module tb_des_search_top;
  import des_search_pkg::*;

  localparam logic [55:0] LIM = 56'd15;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [63:0] plaintext;
  logic [63:0] ciphertext;
  logic [55:0] count;
  logic [63:0] Key;
  logic        Found;
  logic [55:0] lim_count;
  logic [63:0] lim_key;
  logic        lim_found;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  des_search_top dut (
    .clk       (clk),
    .reset     (reset),
    .Start     (Start),
    .plaintext (plaintext),
    .ciphertext(ciphertext),
    .count     (count),
    .Key       (Key),
    .Found     (Found)
  );

  des_search_top #(.COUNT_LIMIT(LIM)) dut_lim (
    .clk       (clk),
    .reset     (reset),
    .Start     (Start),
    .plaintext (plaintext),
    .ciphertext(ciphertext),
    .count     (lim_count),
    .Key       (lim_key),
    .Found     (lim_found)
  );

  // Reference DES tables, 1-based bit numbering (bit 1 = MSB).
  localparam int B_IP [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int B_FP [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam int B_E [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int B_P [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
     2, 8, 24, 14, 32, 27,  3,  9, 19, 13, 30, 6, 22, 11, 4, 25};
  localparam int B_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int B_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int B_SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int B_S [8][4][16] = '{
    '{'{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7},
      '{0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8},
      '{4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0},
      '{15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13}},
    '{'{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10},
      '{3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5},
      '{0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15},
      '{13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9}},
    '{'{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8},
      '{13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1},
      '{13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7},
      '{1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12}},
    '{'{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15},
      '{13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9},
      '{10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4},
      '{3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14}},
    '{'{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9},
      '{14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6},
      '{4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14},
      '{11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3}},
    '{'{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11},
      '{10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8},
      '{9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6},
      '{4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13}},
    '{'{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1},
      '{13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6},
      '{1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2},
      '{6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12}},
    '{'{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7},
      '{1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2},
      '{7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8},
      '{2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}}};

  // Key byte = 7 index bits followed by a bit that makes the one-count odd.
  function automatic logic [63:0] model_key(input logic [55:0] idx);
    logic [63:0] k;
    logic [6:0]  seg;
    k = '0;
    for (int i = 0; i < 8; i++) begin
      seg = idx[7*i +: 7];
      k[8*i +: 8] = {seg, (($countones(seg) % 2) == 0) ? 1'b1 : 1'b0};
    end
    return k;
  endfunction

  function automatic bit parity_ok(input logic [63:0] k);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) if (($countones(k[8*i +: 8]) % 2) != 1) ok = 1'b0;
    return ok;
  endfunction

  // Textbook DES on 1-based bit arrays, with the key schedule expressed as a
  // cumulative rotation of the PC1 halves.
  function automatic logic [63:0] model_des(input logic [63:0] key, input logic [63:0] pt);
    bit cd0 [1:56];
    bit cd  [1:56];
    bit l   [1:32];
    bit r   [1:32];
    bit er  [1:48];
    bit so  [1:32];
    bit fo  [1:32];
    bit pre [1:64];
    bit nb;
    int sh;
    int row;
    int col;
    int val;
    logic [63:0] res;
    res = '0;
    for (int n = 1; n <= 56; n++) cd0[n] = key[64-B_PC1[n-1]];
    for (int n = 1; n <= 32; n++) begin
      l[n] = pt[64-B_IP[n-1]];
      r[n] = pt[64-B_IP[n+31]];
    end
    sh = 0;
    for (int rnd = 0; rnd < 16; rnd++) begin
      sh += B_SH[rnd];
      for (int n = 1; n <= 28; n++) begin
        cd[n]    = cd0[((n - 1 + sh) % 28) + 1];
        cd[n+28] = cd0[((n - 1 + sh) % 28) + 29];
      end
      for (int n = 1; n <= 48; n++) er[n] = r[B_E[n-1]] ^ cd[B_PC2[n-1]];
      for (int j = 0; j < 8; j++) begin
        row = 2 * int'(er[6*j+1]) + int'(er[6*j+6]);
        col = 8 * int'(er[6*j+2]) + 4 * int'(er[6*j+3]) + 2 * int'(er[6*j+4]) + int'(er[6*j+5]);
        val = B_S[j][row][col];
        for (int b = 0; b < 4; b++) so[4*j+1+b] = val[3-b];
      end
      for (int n = 1; n <= 32; n++) fo[n] = so[B_P[n-1]];
      for (int n = 1; n <= 32; n++) begin
        nb   = l[n] ^ fo[n];
        l[n] = r[n];
        r[n] = nb;
      end
    end
    for (int n = 1; n <= 32; n++) begin
      pre[n]    = r[n];
      pre[n+32] = l[n];
    end
    for (int n = 1; n <= 64; n++) res[64-n] = pre[B_FP[n-1]];
    return res;
  endfunction

  // First candidate index in [0, limit] that produces ct, or -1.
  function automatic longint ref_search(input logic [63:0] pt, input logic [63:0] ct,
                                        input longint limit);
    for (longint c = 0; c <= limit; c++) begin
      if (model_des(model_key(56'(c)), pt) == ct) return c;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Restart from FOUND/IDLE and follow the search until Found, with stray Start
  // pulses thrown in while searching.
  task automatic run_search(input longint exp_idx);
    int cyc;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("restart_found_clear", 64'(Found), 64'd0);
    cyc = 0;
    while (cyc < 2000) begin
      if (Found) break;
      check("search_count", 64'(count), 64'(cyc));
      check("search_key", Key, model_key(56'(cyc)));
      Start = ($urandom_range(7, 0) == 0);
      tick();
      Start = 1'b0;
      cyc++;
    end
    check("found_in_budget", 64'(Found), 64'd1);
    check("found_latency", 64'(cyc), 64'(exp_idx + 1));
    check("found_count", 64'(count), 64'(exp_idx));
    check("found_key", Key, model_key(56'(exp_idx)));
    check("found_key_parity", 64'(parity_ok(Key)), 64'd1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] pt_r;
    logic [63:0] ct_r;
    logic [63:0] rnd64;
    longint      tgt;
    longint      exp_idx;

    reset      = 1'b1;
    Start      = 1'b0;
    plaintext  = 64'h8000000000000000;
    ciphertext = 64'h95F8A5E5DD31D900;
    #100;
    tick();
    check("reset_count", 64'(count), 64'd0);
    check("reset_found", 64'(Found), 64'd0);
    check("reset_key", Key, 64'h0101010101010101);
    check("reset_lim_count", 64'(lim_count), 64'd0);
    reset = 1'b0;

    // Known answer: the all-zero index key matches immediately.
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("kat_search_count", 64'(count), 64'd0);
    check("kat_search_found", 64'(Found), 64'd0);
    tick();
    check("kat_found", 64'(Found), 64'd1);
    check("kat_count", 64'(count), 64'd0);
    check("kat_key", Key, 64'h0101010101010101);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("kat_hold_found", 64'(Found), 64'd1);
      check("kat_hold_count", 64'(count), 64'd0);
    end

    // Randomized searches for a key planted at a random small index.
    for (int t = 0; t < 3; t++) begin
      pt_r       = {$urandom, $urandom};
      tgt        = longint'($urandom_range(300, 20));
      plaintext  = pt_r;
      ciphertext = model_des(model_key(56'(tgt)), pt_r);
      exp_idx    = ref_search(pt_r, ciphertext, tgt);
      run_search(exp_idx);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      check("found_hold", 64'(Found), 64'd1);
      check("found_hold_count", 64'(count), 64'(exp_idx));
    end

    // Reset wins over a match present in the same cycle.
    plaintext  = 64'h8000000000000000;
    ciphertext = 64'h95F8A5E5DD31D900;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_over_match_found", 64'(Found), 64'd0);
    check("reset_over_match_count", 64'(count), 64'd0);

    // Unmatched target for the reset-mid-search and exhaustion runs.
    pt_r = {$urandom, $urandom};
    plaintext = pt_r;
    do begin
      ct_r = {$urandom, $urandom};
    end while (ref_search(pt_r, ct_r, 40) != -1);
    ciphertext = ct_r;

    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("mid_search_count5", 64'(count), 64'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_reset_count", 64'(count), 64'd0);
    check("mid_reset_found", 64'(Found), 64'd0);
    check("mid_reset_key", Key, 64'h0101010101010101);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_stays", 64'(count), 64'd0);
    end
    reset = 1'b1;
    Start = 1'b1;
    tick();
    reset = 1'b0;
    Start = 1'b0;
    tick();
    check("reset_over_start", 64'(count), 64'd0);

    // Exhaustion with the small-limit instance; main instance keeps counting.
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int k = 0; k <= 15; k++) begin
      check("exh_lim_count", 64'(lim_count), 64'(k));
      check("exh_main_count", 64'(count), 64'(k));
      tick();
    end
    for (int j = 0; j < 4; j++) begin
      check("exh_hold_count", 64'(lim_count), 64'd15);
      check("exh_hold_found", 64'(lim_found), 64'd0);
      check("exh_main_beyond", 64'(count), 64'(16 + j));
      tick();
    end
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("exh_restart_count", 64'(lim_count), 64'd0);
    check("start_ignored_in_search", 64'(count), 64'd21);
    tick();
    check("exh_restart_step", 64'(lim_count), 64'd1);
    check("main_continues", 64'(count), 64'd22);

    // Key expansion over random indices.
    for (int i = 0; i < 8; i++) begin
      rnd64 = {$urandom, $urandom};
      check("expand_key", expand_key(rnd64[55:0]), model_key(rnd64[55:0]));
      check("expand_parity", 64'(parity_ok(expand_key(rnd64[55:0]))), 64'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
